// File: rtl/lightboard_pkg.sv
// Shared constants, pixel/ink types and pure helpers for the lightboard ink compositor.
package lightboard_pkg;

    localparam int unsigned H_PIX   = 320;
    localparam int unsigned V_PIX   = 240;
    localparam int unsigned BRUSH_R = 4;

    typedef struct packed {
        logic [1:0] tag;
        logic [5:0] luma;
    } px_t;

    typedef enum logic [1:0] {
        INK_NONE = 2'b00,
        INK_PINK = 2'b01,
        INK_B    = 2'b10,
        INK_C    = 2'b11
    } ink_t;

    // Luma always refreshes; only the ink tag depends on brush hit and mode.
    function automatic px_t compose_px(input logic hit, input logic erase, input ink_t ink,
                                       input logic [5:0] luma, input px_t stored);
        px_t res;
        res.luma = luma;
        if (!hit) begin
            res.tag = stored.tag;
        end else if (!erase && (ink != INK_NONE)) begin
            res.tag = ink;
        end else begin
            res.tag = 2'b00;
        end
        return res;
    endfunction

    function automatic logic [16:0] pix_addr(input logic [9:0] v, input logic [10:0] h);
        return ({7'd0, v} << 8) + ({7'd0, v} << 6) + {6'd0, h};
    endfunction

endpackage

// File: rtl/brush_hit.sv
// Square brush window test: pixel lies within BRUSH_R of the pen COM on both axes.
module brush_hit
    import lightboard_pkg::*;
(
    input  logic [10:0] x_com,
    input  logic [9:0]  y_com,
    input  logic [10:0] px_x,
    input  logic [9:0]  px_y,
    input  logic        com_seen,
    output logic        hit
);

    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic [11:0]        adx_s;
    logic [11:0]        ady_s;

    // Signed differences stay in range, so the window clips at frame edges without wrapping.
    always_comb begin
        dx_s  = $signed({1'b0, px_x}) - $signed({1'b0, x_com});
        dy_s  = $signed({2'b00, px_y}) - $signed({2'b00, y_com});
        adx_s = dx_s[11] ? $unsigned(-dx_s) : $unsigned(dx_s);
        ady_s = dy_s[11] ? $unsigned(-dy_s) : $unsigned(dy_s);
        hit   = com_seen && (adx_s <= 12'(BRUSH_R)) && (ady_s <= 12'(BRUSH_R));
    end

endmodule

// File: rtl/compare_unit.sv
// Eight-phase read-modify-write ink compositor sharing one frame BRAM port with the VGA reader.
module compare_unit
    import lightboard_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_com_in,
    input  logic [9:0]  y_com_in,
    input  logic        com_valid_in,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [5:0]  y_pixel,
    input  logic [1:0]  color_select,
    input  logic        write_erase_select,
    input  logic [7:0]  pixel_from_bram,
    output logic [7:0]  pixel_for_bram,
    output logic [16:0] pixel_addr_forbram,
    output logic        valid_pixel_forbram,
    output logic        pixelread_forvga_valid,
    output logic        pixeladdr_forvga_valid
);

    logic [2:0]  phase_q,    phase_d;
    logic [10:0] x_com_q,    x_com_d;
    logic [9:0]  y_com_q,    y_com_d;
    logic        com_seen_q, com_seen_d;
    logic [10:0] snap_x_q,   snap_x_d;
    logic [9:0]  snap_y_q,   snap_y_d;
    logic        snap_seen_q, snap_seen_d;
    logic [10:0] h_q,        h_d;
    logic [9:0]  v_q,        v_d;
    logic [5:0]  y_q,        y_d;
    logic        void_q,     void_d;
    logic [16:0] addr_q,     addr_d;
    logic [7:0]  data_q,     data_d;
    logic        wr_q,       wr_d;
    logic        vga_addr_q, vga_addr_d;
    logic        vga_rd_q,   vga_rd_d;
    logic        hit_s;
    logic        void_now_s;

    brush_hit u_brush_hit (
        .x_com    (snap_x_q),
        .y_com    (snap_y_q),
        .px_x     (h_q),
        .px_y     (v_q),
        .com_seen (snap_seen_q),
        .hit      (hit_s)
    );

    // Next-state logic; outputs are decoded from the upcoming phase so they are registered.
    always_comb begin
        phase_d     = phase_q + 3'd1;
        void_now_s  = (hcount >= 11'(H_PIX)) || (vcount >= 10'(V_PIX));
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_seen_d = snap_seen_q;
        h_d         = h_q;
        v_d         = v_q;
        y_d         = y_q;
        void_d      = void_q;
        addr_d      = 17'd0;
        data_d      = 8'd0;
        wr_d        = 1'b0;
        vga_addr_d  = (phase_d >= 3'd5);
        vga_rd_d    = (phase_d == 3'd7);

        if (com_valid_in) begin
            x_com_d    = x_com_in;
            y_com_d    = y_com_in;
            com_seen_d = 1'b1;
        end else begin
            x_com_d    = x_com_q;
            y_com_d    = y_com_q;
            com_seen_d = com_seen_q;
        end

        case (phase_q)
            3'd0: begin
                snap_x_d    = x_com_q;
                snap_y_d    = y_com_q;
                snap_seen_d = com_seen_q;
                h_d         = hcount;
                v_d         = vcount;
                y_d         = y_pixel;
                void_d      = void_now_s;
                addr_d      = void_now_s ? 17'd0 : pix_addr(vcount, hcount);
            end
            3'd1, 3'd2: begin
                addr_d = addr_q;
            end
            3'd3: begin
                addr_d = addr_q;
                wr_d   = ~void_q;
                data_d = void_q ? 8'd0 :
                         compose_px(hit_s, write_erase_select, ink_t'(color_select),
                                    y_q, px_t'(pixel_from_bram));
            end
            default: begin
                addr_d = 17'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any in-flight job.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            phase_q     <= 3'd0;
            x_com_q     <= 11'd0;
            y_com_q     <= 10'd0;
            com_seen_q  <= 1'b0;
            snap_x_q    <= 11'd0;
            snap_y_q    <= 10'd0;
            snap_seen_q <= 1'b0;
            h_q         <= 11'd0;
            v_q         <= 10'd0;
            y_q         <= 6'd0;
            void_q      <= 1'b0;
            addr_q      <= 17'd0;
            data_q      <= 8'd0;
            wr_q        <= 1'b0;
            vga_addr_q  <= 1'b0;
            vga_rd_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            x_com_q     <= x_com_d;
            y_com_q     <= y_com_d;
            com_seen_q  <= com_seen_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_seen_q <= snap_seen_d;
            h_q         <= h_d;
            v_q         <= v_d;
            y_q         <= y_d;
            void_q      <= void_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            vga_addr_q  <= vga_addr_d;
            vga_rd_q    <= vga_rd_d;
        end
    end

    assign pixel_for_bram         = data_q;
    assign pixel_addr_forbram     = addr_q;
    assign valid_pixel_forbram    = wr_q;
    assign pixelread_forvga_valid = vga_rd_q;
    assign pixeladdr_forvga_valid = vga_addr_q;

endmodule

// File: tb/tb_compare_unit.sv
// Self-checking bench for compare_unit: directed cases plus randomized jobs against a job-level model.
module tb_compare_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] x_com_in;
    logic [9:0]  y_com_in;
    logic        com_valid_in;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [5:0]  y_pixel;
    logic [1:0]  color_select;
    logic        write_erase_select;
    logic [7:0]  pixel_from_bram;
    logic [7:0]  pixel_for_bram;
    logic [16:0] pixel_addr_forbram;
    logic        valid_pixel_forbram;
    logic        pixelread_forvga_valid;
    logic        pixeladdr_forvga_valid;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_seen;
    int m_xc;
    int m_yc;

    always #5 clk_in = ~clk_in;

    compare_unit dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .x_com_in               (x_com_in),
        .y_com_in               (y_com_in),
        .com_valid_in           (com_valid_in),
        .hcount                 (hcount),
        .vcount                 (vcount),
        .y_pixel                (y_pixel),
        .color_select           (color_select),
        .write_erase_select     (write_erase_select),
        .pixel_from_bram        (pixel_from_bram),
        .pixel_for_bram         (pixel_for_bram),
        .pixel_addr_forbram     (pixel_addr_forbram),
        .valid_pixel_forbram    (valid_pixel_forbram),
        .pixelread_forvga_valid (pixelread_forvga_valid),
        .pixeladdr_forvga_valid (pixeladdr_forvga_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Expected BRAM write data for one job from the compositing rules.
    function automatic int model_px(input int h, input int v, input int y, input int color,
                                    input bit erase, input int bram);
        bit hit;
        hit = m_seen && (iabs(h - m_xc) <= 4) && (iabs(v - m_yc) <= 4);
        if (hit && !erase && color != 0) return color * 64 + y;
        if (hit) return y;
        return (bram / 64) * 64 + y;
    endfunction

    task automatic check_idle(input string ctx);
        check_eq({ctx, "/addr"}, 32'(pixel_addr_forbram), 32'd0);
        check_eq({ctx, "/wr"},   32'(valid_pixel_forbram), 32'd0);
        check_eq({ctx, "/vga_a"}, 32'(pixeladdr_forvga_valid), 32'd0);
        check_eq({ctx, "/vga_r"}, 32'(pixelread_forvga_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_in       = 1'b0;
        com_valid_in = 1'b0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
        end
        check_idle("reset_hold");
        check_eq("reset_hold/data", 32'(pixel_for_bram), 32'd0);
        m_seen = 1'b0;
        m_xc   = 0;
        m_yc   = 0;
        rst_in = 1'b1;
    endtask

    // Runs one 8-cycle job starting in a P0 cycle; abort_k >= 0 asserts reset in that cycle.
    task automatic run_job(input string name, input int h, input int v, input int y,
                           input int color, input bit erase, input int bram,
                           input bit do_com, input int cx, input int cy, input int abort_k);
        bit void_job;
        int exp_addr;
        int exp_data;
        void_job = (h >= 320) || (v >= 240);
        exp_addr = void_job ? 0 : v * 320 + h;
        exp_data = model_px(h, v, y, color, erase, bram);
        for (int k = 0; k < 8; k++) begin
            check_eq({name, "/addr"}, 32'(pixel_addr_forbram),
                     32'((k >= 1 && k <= 4) ? exp_addr : 0));
            check_eq({name, "/wr"}, 32'(valid_pixel_forbram), 32'(k == 4 && !void_job));
            check_eq({name, "/vga_a"}, 32'(pixeladdr_forvga_valid), 32'(k >= 5));
            check_eq({name, "/vga_r"}, 32'(pixelread_forvga_valid), 32'(k == 7));
            if (k == 4 && !void_job) begin
                check_eq({name, "/data"}, 32'(pixel_for_bram), 32'(exp_data));
            end
            if (k == 0) begin
                hcount             = 11'(h);
                vcount             = 10'(v);
                y_pixel            = 6'(y);
                color_select       = 2'(color);
                write_erase_select = erase;
            end else begin
                hcount  = 11'($urandom);
                vcount  = 10'($urandom);
                y_pixel = 6'($urandom);
            end
            pixel_from_bram = (k == 3) ? 8'(bram) : 8'($urandom);
            com_valid_in    = do_com && (k == 2);
            x_com_in        = (do_com && k == 2) ? 11'(cx) : 11'($urandom);
            y_com_in        = (do_com && k == 2) ? 10'(cy) : 10'($urandom);
            if (k == abort_k) rst_in = 1'b0;
            @(posedge clk_in);
            #1;
            com_valid_in = 1'b0;
            if (k == abort_k) begin
                check_idle({name, "/abort"});
                @(posedge clk_in);
                #1;
                check_idle({name, "/abort2"});
                m_seen = 1'b0;
                m_xc   = 0;
                m_yc   = 0;
                rst_in = 1'b1;
                return;
            end
        end
        if (do_com) begin
            m_seen = 1'b1;
            m_xc   = cx;
            m_yc   = cy;
        end
    endtask

    initial begin
        int h, v, cx, cy;
        rst_in = 1'b0;
        x_com_in = 11'd0; y_com_in = 10'd0; com_valid_in = 1'b0;
        hcount = 11'd0; vcount = 10'd0; y_pixel = 6'd0;
        color_select = 2'd0; write_erase_select = 1'b0; pixel_from_bram = 8'd0;

        do_reset();
        run_job("first_job", 10, 20, 7, 1, 1'b0, 8'h81, 1'b1, 150, 100, -1);
        run_job("pink_miss", 100, 100, 6'b010101, 1, 1'b0, 8'b00111111, 1'b0, 0, 0, -1);
        run_job("pink_hit", 151, 100, 6'b010111, 1, 1'b0, 8'b00100000, 1'b0, 0, 0, -1);
        run_job("erase_hit", 150, 100, 6'b000011, 1, 1'b1, 8'b01000000, 1'b0, 0, 0, -1);
        run_job("color0_hit", 146, 104, 6'b111000, 0, 1'b0, 8'b11000000, 1'b0, 0, 0, -1);
        run_job("edge_miss", 155, 100, 6'b000111, 2, 1'b0, 8'b01000000, 1'b0, 0, 0, -1);
        do_reset();
        run_job("no_com", 150, 100, 6'b000001, 1, 1'b0, 8'b10001111, 1'b0, 0, 0, -1);
        run_job("void_h", 320, 5, 6'd9, 1, 1'b0, 8'hff, 1'b1, 0, 0, -1);
        run_job("corner_hit", 3, 2, 6'd33, 3, 1'b0, 8'h00, 1'b1, 319, 239, -1);
        run_job("far_corner", 317, 239, 6'd34, 2, 1'b0, 8'h40, 1'b0, 0, 0, -1);
        run_job("void_v", 10, 240, 6'd9, 1, 1'b0, 8'hff, 1'b0, 0, 0, -1);
        run_job("abort_p2", 150, 100, 6'd5, 1, 1'b0, 8'h00, 1'b0, 0, 0, 2);
        run_job("after_abort", 319, 239, 6'd5, 1, 1'b0, 8'h80, 1'b0, 0, 0, -1);

        for (int j = 0; j < 48; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                h = int'($urandom_range(0, 399));
                v = int'($urandom_range(0, 269));
            end else begin
                h = m_xc + int'($urandom_range(0, 12)) - 6;
                v = m_yc + int'($urandom_range(0, 12)) - 6;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
            end
            case ($urandom_range(0, 2))
                0: cx = 0;
                1: cx = 319;
                default: cx = int'($urandom_range(0, 319));
            endcase
            cy = ($urandom_range(0, 2) == 0) ? 239 : int'($urandom_range(0, 239));
            run_job("rand", h, v, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)),
                    (j % 6 == 0), cx, cy, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
